// File: rtl/milano_pkg.sv
`default_nettype none
// ============================================================================
// Module      : milano_pkg
// Description : Shared types and constants for the milano core control path.
// Revision    : 1.0 - initial release
// ============================================================================
package milano_pkg;

    localparam int REG_ADDR_WIDTH = 5;

    localparam logic [31:0] MCAUSE_ECALL  = 32'd11;
    localparam logic [31:0] MCAUSE_EBREAK = 32'd3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TRAP_SAVE = 2'd1,
        TRAP_VEC  = 2'd2
    } ctrl_state_e;

endpackage : milano_pkg
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Load-use comparator between the load in EX and the ID reads.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import milano_pkg::*;
(
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_id_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_id_i,
    input  logic                      rs1_used_id_i,
    input  logic                      rs2_used_id_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_ex_i,
    input  logic                      lsu_req_ex_i,
    input  logic                      lsu_we_ex_i,
    output logic                      load_use_o
);

    logic w_is_load;
    logic w_rs1_hit;
    logic w_rs2_hit;

    // x0 is never a real producer, so a load to it cannot create a hazard.
    assign w_is_load  = lsu_req_ex_i & ~lsu_we_ex_i & (rd_addr_ex_i != '0);
    assign w_rs1_hit  = rs1_used_id_i & (rs1_addr_id_i == rd_addr_ex_i);
    assign w_rs2_hit  = rs2_used_id_i & (rs2_addr_id_i == rd_addr_ex_i);
    assign load_use_o = w_is_load & (w_rs1_hit | w_rs2_hit);

endmodule : hazard_detect
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline stall/flush arbiter, PC redirect and trap-entry FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
    import milano_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_addr_id_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_addr_id_i,
    input  logic                      rs1_used_id_i,
    input  logic                      rs2_used_id_i,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_ex_i,
    input  logic                      lsu_req_ex_i,
    input  logic                      lsu_we_ex_i,
    input  logic                      lsu_gnt_i,
    input  logic                      md_sel_ex_i,
    input  logic                      md_busy_i,
    input  logic                      jump_flag_ex_i,
    input  logic [ADDR_WIDTH-1:0]     jump_addr_ex_i,
    input  logic                      ecall_flag_ex_i,
    input  logic                      ebreak_flag_ex_i,
    input  logic                      mret_flag_ex_i,
    input  logic [ADDR_WIDTH-1:0]     instr_addr_ex_i,
    input  logic [ADDR_WIDTH-1:0]     mtvec_i,
    input  logic [ADDR_WIDTH-1:0]     mepc_i,
    output logic                      stall_if_o,
    output logic                      stall_id_o,
    output logic                      stall_ex_o,
    output logic                      refresh_if_id_o,
    output logic                      refresh_id_ex_o,
    output logic                      pc_redirect_o,
    output logic [ADDR_WIDTH-1:0]     pc_redirect_addr_o,
    output logic                      csr_trap_we_o,
    output logic [ADDR_WIDTH-1:0]     csr_mepc_o,
    output logic [31:0]               csr_mcause_o,
    output logic                      trap_busy_o
);

    ctrl_state_e           r_state;
    ctrl_state_e           w_state_next;
    logic [ADDR_WIDTH-1:0] r_trap_pc;
    logic [31:0]           r_trap_cause;

    logic w_load_use;
    logic w_wait;
    logic w_trap_req;

    hazard_detect u_hazard_detect (
        .rs1_addr_id_i (rs1_addr_id_i),
        .rs2_addr_id_i (rs2_addr_id_i),
        .rs1_used_id_i (rs1_used_id_i),
        .rs2_used_id_i (rs2_used_id_i),
        .rd_addr_ex_i  (rd_addr_ex_i),
        .lsu_req_ex_i  (lsu_req_ex_i),
        .lsu_we_ex_i   (lsu_we_ex_i),
        .load_use_o    (w_load_use)
    );

    assign w_wait     = (md_sel_ex_i & md_busy_i) | (lsu_req_ex_i & ~lsu_gnt_i);
    assign w_trap_req = ecall_flag_ex_i | ebreak_flag_ex_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= IDLE;
            r_trap_pc    <= '0;
            r_trap_cause <= '0;
        end else begin
            r_state <= w_state_next;
            if ((r_state == IDLE) && w_trap_req) begin
                r_trap_pc    <= instr_addr_ex_i;
                r_trap_cause <= ecall_flag_ex_i ? MCAUSE_ECALL : MCAUSE_EBREAK;
            end
        end
    end

    // Exactly one event class drives the outputs; the if/else order is the priority.
    always_comb begin
        w_state_next       = r_state;
        stall_if_o         = 1'b0;
        stall_id_o         = 1'b0;
        stall_ex_o         = 1'b0;
        refresh_if_id_o    = 1'b0;
        refresh_id_ex_o    = 1'b0;
        pc_redirect_o      = 1'b0;
        pc_redirect_addr_o = '0;
        csr_trap_we_o      = 1'b0;
        csr_mepc_o         = '0;
        csr_mcause_o       = '0;

        case (r_state)
            TRAP_SAVE: begin
                csr_trap_we_o   = 1'b1;
                csr_mepc_o      = r_trap_pc;
                csr_mcause_o    = r_trap_cause;
                refresh_if_id_o = 1'b1;
                refresh_id_ex_o = 1'b1;
                stall_if_o      = 1'b1;
                w_state_next    = TRAP_VEC;
            end
            TRAP_VEC: begin
                pc_redirect_o      = 1'b1;
                pc_redirect_addr_o = mtvec_i;
                refresh_if_id_o    = 1'b1;
                refresh_id_ex_o    = 1'b1;
                w_state_next       = IDLE;
            end
            default: begin
                if (w_trap_req) begin
                    refresh_if_id_o = 1'b1;
                    refresh_id_ex_o = 1'b1;
                    stall_if_o      = 1'b1;
                    w_state_next    = TRAP_SAVE;
                end else if (mret_flag_ex_i) begin
                    pc_redirect_o      = 1'b1;
                    pc_redirect_addr_o = mepc_i;
                    refresh_if_id_o    = 1'b1;
                    refresh_id_ex_o    = 1'b1;
                end else if (jump_flag_ex_i) begin
                    pc_redirect_o      = 1'b1;
                    pc_redirect_addr_o = jump_addr_ex_i;
                    refresh_if_id_o    = 1'b1;
                    refresh_id_ex_o    = 1'b1;
                end else if (w_wait) begin
                    stall_if_o = 1'b1;
                    stall_id_o = 1'b1;
                    stall_ex_o = 1'b1;
                end else if (w_load_use) begin
                    // Hold IF/ID but let EX advance into a flushed slot: one bubble.
                    stall_if_o      = 1'b1;
                    stall_id_o      = 1'b1;
                    refresh_id_ex_o = 1'b1;
                end
            end
        endcase
    end

    assign trap_busy_o = (r_state != IDLE);

endmodule : pipe_ctrl
`default_nettype wire
